dmem_responder: RTL and testbench

// - Responder for the core data port: serves d_addr/d_we/d_wr_data, returns d_rd_data one cycle later.
// - Holds the on-chip data RAM and a small MMIO block (64-bit timer, GPIO out, tohost/halt).
// - Sits beside the core at top level. No stall or handshake: every access completes in fixed latency.

---
 rtl/dmem_pkg.sv | 56 +++++
 rtl/dmem_responder_mmio_timer.sv | 44 ++++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the core data port: access sizes, MMIO offsets, reset constants.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

    // Encoding of d_we; the core's LSU drives this same enum
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_B    = 2'b01,
        MEM_H    = 2'b10,
        MEM_W    = 2'b11
    } mem_size_t;

    // Byte offsets inside the MMIO window; only d_addr[4:2] is decoded
    localparam logic [4:0] MMIO_MTIME_LO    = 5'h00;
    localparam logic [4:0] MMIO_MTIME_HI    = 5'h04;
    localparam logic [4:0] MMIO_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MMIO_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MMIO_GPIO_OUT    = 5'h10;
    localparam logic [4:0] MMIO_TOHOST      = 5'h14;

    // Compare value out of reset: the timer interrupt cannot fire until software programs it
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // One RAM write: per-lane byte enables plus lane-replicated data
    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] dat;
    } ram_wr_t;

    // Byte-lane mask for a store; zero for reads and for misaligned stores
    function automatic logic [3:0] store_lanes(input mem_size_t size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            MEM_B:   be = 4'b0001 << a;
            MEM_H:   if (!a[0]) be = a[1] ? 4'b1100 : 4'b0011;
            MEM_W:   if (a == 2'b00) be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate LSB-aligned store data across all lanes so the byte enables pick the right copy
    function automatic logic [31:0] store_data(input mem_size_t size, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (size)
            MEM_B:   r = {4{d[7:0]}};
            MEM_H:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// 64-bit free-running mtime, LO-read shadow of the high word, mtimecmp and the timer interrupt.
// Latency: register updates land on the edge after the request; timer_irq is one cycle behind the compare.
// Backpressure: none; every request is applied on the cycle it is presented.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lo_rd,
    input  logic        cmp_lo_we,
    input  logic        cmp_hi_we,
    input  logic [31:0] wr_data,
    output logic [63:0] mtime,
    output logic [31:0] hi_shadow,
    output logic [63:0] mtimecmp,
    output logic        timer_irq
);

    // Counter, shadow capture, compare register and registered compare result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime     <= 64'd0;
            hi_shadow <= 32'd0;
            mtimecmp  <= MTIMECMP_RST;
            timer_irq <= 1'b0;
        end else begin
            // Wraps naturally from all-ones back to zero
            mtime <= mtime + 64'd1;
            // Capturing the high half together with the low-half read keeps LO-then-HI coherent
            if (lo_rd) begin
                hi_shadow <= mtime[63:32];
            end
            if (cmp_lo_we) begin
                mtimecmp[31:0] <= wr_data;
            end
            if (cmp_hi_we) begin
                mtimecmp[63:32] <= wr_data;
            end
            // Uses the pre-write mtimecmp, so a new compare value counts from the next cycle
            timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: byte-lane RAM plus MMIO (timer, GPIO, tohost/halt) behind one address decode.
// Latency: read data exactly one cycle after d_addr; stores commit on the same edge.
// Backpressure: none; fixed latency, illegal stores are dropped and flagged on access_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_we,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rd_data,
    output logic        timer_irq,
    output logic [31:0] gpio_out,
    output logic        halt,
    output logic [31:0] tohost_val,
    output logic        access_err
);

    localparam int AW = $clog2(MEM_WORDS);

    mem_size_t      size;
    logic           is_mmio;
    logic           is_store;
    logic [4:0]     mmio_off;
    logic [AW-1:0]  ram_idx;
    logic [3:0]     lanes;
    ram_wr_t        ram_wr;
    logic           mmio_sw;
    logic           lo_rd;
    logic           cmp_lo_we;
    logic           cmp_hi_we;
    logic           gpio_we;
    logic           tohost_we;
    logic           store_err;
    logic [31:0]    mmio_rd;
    logic [31:0]    mmio_q;
    logic [31:0]    ram_q;
    logic           rd_is_ram;
    logic [63:0]    mtime;
    logic [63:0]    mtimecmp;
    logic [31:0]    hi_shadow;
    logic           unused_bits;

    // Address bits above the RAM index alias in RAM space and are ignored in MMIO space
    assign unused_bits = ^{d_addr[30:0], mtime[63:32]};

    // Region select, RAM indexing and store lane/data generation
    always_comb begin
        size       = mem_size_t'(d_we);
        is_mmio    = (d_addr[31] == MMIO_BASE[31]);
        is_store   = (size != MEM_NONE);
        mmio_off   = {d_addr[4:2], 2'b00};
        ram_idx    = d_addr[AW+1:2];
        lanes      = store_lanes(size, d_addr[1:0]);
        ram_wr.be  = is_mmio ? 4'b0000 : lanes;
        ram_wr.dat = store_data(size, d_wr_data);
    end

    // MMIO write strobes, shadow capture and illegal-store detection
    always_comb begin
        mmio_sw   = is_mmio && (size == MEM_W) && (d_addr[1:0] == 2'b00);
        cmp_lo_we = mmio_sw && (mmio_off == MMIO_MTIMECMP_LO);
        cmp_hi_we = mmio_sw && (mmio_off == MMIO_MTIMECMP_HI);
        gpio_we   = mmio_sw && (mmio_off == MMIO_GPIO_OUT);
        tohost_we = mmio_sw && (mmio_off == MMIO_TOHOST);
        // Reads happen on every cycle regardless of d_we, so the shadow follows any LO access
        lo_rd     = is_mmio && (mmio_off == MMIO_MTIME_LO);
        if (is_mmio) begin
            store_err = is_store && !(cmp_lo_we || cmp_hi_we || gpio_we || tohost_we);
        end else begin
            store_err = is_store && (lanes == 4'b0000);
        end
    end

    // MMIO read mux; TOHOST and unmapped offsets read as zero
    always_comb begin
        mmio_rd = 32'd0;
        case (mmio_off)
            MMIO_MTIME_LO:    mmio_rd = mtime[31:0];
            MMIO_MTIME_HI:    mmio_rd = hi_shadow;
            MMIO_MTIMECMP_LO: mmio_rd = mtimecmp[31:0];
            MMIO_MTIMECMP_HI: mmio_rd = mtimecmp[63:32];
            MMIO_GPIO_OUT:    mmio_rd = gpio_out;
            default:          mmio_rd = 32'd0;
        endcase
    end

    // Four byte-wide lanes; read-before-write gives old data on a same-word collision
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [MEM_WORDS];
        logic [7:0] lane_q;

        // Lane write with byte enable and unreset registered read
        always_ff @(posedge clk) begin
            if (ram_wr.be[i]) begin
                mem[ram_idx] <= ram_wr.dat[8*i +: 8];
            end
            lane_q <= mem[ram_idx];
        end

        assign ram_q[8*i +: 8] = lane_q;
    end

    // Read source select, MMIO read data, GPIO/tohost/halt and the error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_is_ram  <= 1'b0;
            mmio_q     <= 32'd0;
            gpio_out   <= 32'd0;
            tohost_val <= 32'd0;
            halt       <= 1'b0;
            access_err <= 1'b0;
        end else begin
            rd_is_ram  <= !is_mmio;
            mmio_q     <= is_mmio ? mmio_rd : 32'd0;
            access_err <= store_err;
            if (gpio_we) begin
                gpio_out <= d_wr_data;
            end
            // halt is sticky; later writes still refresh the reported value
            if (tohost_we) begin
                tohost_val <= d_wr_data;
                halt       <= 1'b1;
            end
        end
    end

    // RAM read data is unreset, so reset parks the mux on the zeroed MMIO path
    assign d_rd_data = rd_is_ram ? ram_q : mmio_q;

    mmio_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .lo_rd     (lo_rd),
        .cmp_lo_we (cmp_lo_we),
        .cmp_hi_we (cmp_hi_we),
        .wr_data   (d_wr_data),
        .mtime     (mtime),
        .hi_shadow (hi_shadow),
        .mtimecmp  (mtimecmp),
        .timer_irq (timer_irq)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-addressed reference model checked every cycle.
// Latency: inputs driven on the falling edge, outputs compared on the following falling edge.
// Backpressure: n/a.
module tb_dmem_responder;

    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d_addr = 32'd0;
    logic [1:0]  d_we = 2'd0;
    logic [31:0] d_wr_data = 32'd0;
    logic [31:0] d_rd_data;
    logic        timer_irq;
    logic [31:0] gpio_out;
    logic        halt;
    logic [31:0] tohost_val;
    logic        access_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_mem   [MW*4];
    bit          m_known [MW*4];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [31:0] m_gpio;
    logic [31:0] m_tohost;
    bit          m_halt;
    logic [31:0] e_rd;
    bit          e_rd_known;
    bit          e_err;
    bit          e_irq;

    always #5 clk = ~clk;

    dmem_responder #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_addr     (d_addr),
        .d_we       (d_we),
        .d_wr_data  (d_wr_data),
        .d_rd_data  (d_rd_data),
        .timer_irq  (timer_irq),
        .gpio_out   (gpio_out),
        .halt       (halt),
        .tohost_val (tohost_val),
        .access_err (access_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime    = 64'd0;
        m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
        m_shadow   = 32'd0;
        m_gpio     = 32'd0;
        m_tohost   = 32'd0;
        m_halt     = 1'b0;
        e_rd       = 32'd0;
        e_rd_known = 1'b1;
        e_err      = 1'b0;
        e_irq      = 1'b0;
    endtask

    // One clock edge of the architectural behaviour, from the inputs currently on the port
    task automatic model_edge();
        logic [31:0] a;
        logic [4:0]  off;
        logic [31:0] rd;
        bit          rk;
        bit          ok;
        bit          irq;
        int          nb;
        int          wi;
        a   = d_addr;
        off = a[4:0] & 5'h1C;
        wi  = int'((a >> 2) % MW);
        irq = (m_mtime >= m_cmp);
        rd  = 32'd0;
        rk  = 1'b1;
        if (a[31]) begin
            case (off)
                5'h00: begin rd = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
                5'h04: rd = m_shadow;
                5'h08: rd = m_cmp[31:0];
                5'h0C: rd = m_cmp[63:32];
                5'h10: rd = m_gpio;
                default: rd = 32'd0;
            endcase
        end else begin
            for (int k = 0; k < 4; k++) begin
                rd[8*k +: 8] = m_mem[wi*4 + k];
                if (!m_known[wi*4 + k]) rk = 1'b0;
            end
        end
        nb = (d_we == 2'd1) ? 1 : (d_we == 2'd2) ? 2 : (d_we == 2'd3) ? 4 : 0;
        ok = 1'b1;
        if (nb != 0) begin
            if (a[31]) begin
                ok = (nb == 4) && (a[1:0] == 2'b00) && (off inside {5'h08, 5'h0C, 5'h10, 5'h14});
                if (ok) begin
                    case (off)
                        5'h08: m_cmp[31:0]  = d_wr_data;
                        5'h0C: m_cmp[63:32] = d_wr_data;
                        5'h10: m_gpio       = d_wr_data;
                        default: begin m_tohost = d_wr_data; m_halt = 1'b1; end
                    endcase
                end
            end else begin
                ok = ((a % nb) == 0);
                if (ok) begin
                    for (int k = 0; k < nb; k++) begin
                        m_mem[wi*4 + int'(a[1:0]) + k]   = d_wr_data[8*k +: 8];
                        m_known[wi*4 + int'(a[1:0]) + k] = 1'b1;
                    end
                end
            end
        end
        e_rd       = rd;
        e_rd_known = rk;
        e_err      = (nb != 0) && !ok;
        e_irq      = irq;
        m_mtime    = m_mtime + 64'd1;
    endtask

    task automatic compare();
        if (e_rd_known) chk("rd_data", d_rd_data, e_rd);
        chk("access_err", 32'(access_err), 32'(e_err));
        chk("timer_irq",  32'(timer_irq),  32'(e_irq));
        chk("gpio_out",   gpio_out,        m_gpio);
        chk("halt",       32'(halt),       32'(m_halt));
        chk("tohost_val", tohost_val,      m_tohost);
    endtask

    // Called just after a falling edge; leaves the bench on the next falling edge
    task automatic cyc(input logic [1:0] we, input logic [31:0] addr, input logic [31:0] data);
        d_we      = we;
        d_addr    = addr;
        d_wr_data = data;
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        bit found;
        model_reset();
        #3 rst = 1'b0;
        model_reset();
        @(negedge clk);
        compare();
        chk("reset_rd",   d_rd_data, 32'h0);
        chk("reset_halt", 32'(halt), 32'h0);
        rst = 1'b1;

        // Timer: compare = 100, interrupt follows mtime by one registered cycle
        cyc(2'd3, 32'h8000_000C, 32'd0);
        cyc(2'd3, 32'h8000_0008, 32'd100);
        cyc(2'd0, 32'h8000_0008, 32'd0);
        chk("cmp_lo_rd", d_rd_data, 32'd100);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(2'd0, 32'h8000_0000, 32'd0);
            if (d_rd_data == 32'd99) chk("irq_before", 32'(timer_irq), 32'd0);
            if (d_rd_data == 32'd100) begin
                chk("irq_rise", 32'(timer_irq), 32'd1);
                found = 1'b1;
            end
        end
        chk("irq_seen", 32'(found), 32'd1);

        // Word store then 1-cycle read
        cyc(2'd3, 32'h0000_0040, 32'h0);
        cyc(2'd3, 32'h0000_0010, 32'hDEAD_BEEF);
        cyc(2'd0, 32'h0000_0040, 32'h0);
        cyc(2'd0, 32'h0000_0010, 32'h0);
        chk("sw_rd", d_rd_data, 32'hDEAD_BEEF);
        cyc(2'd0, 32'h0000_0040, 32'h0);
        chk("rd_next", d_rd_data, 32'h0);

        // Byte and half stores merge into the word
        cyc(2'd1, 32'h0000_0011, 32'h0000_00AA);
        cyc(2'd2, 32'h0000_0012, 32'h0000_1234);
        cyc(2'd0, 32'h0000_0010, 32'h0);
        chk("sb_sh_rd", d_rd_data, 32'h1234_AAEF);

        // Misaligned stores are dropped
        cyc(2'd3, 32'h0000_0020, 32'h5566_7788);
        cyc(2'd2, 32'h0000_0021, 32'h0000_FFFF);
        chk("sh_mis_err", 32'(access_err), 32'd1);
        cyc(2'd0, 32'h0000_0020, 32'h0);
        chk("err_pulse", 32'(access_err), 32'd0);
        cyc(2'd3, 32'h0000_0022, 32'hFFFF_FFFF);
        chk("sw_mis_err", 32'(access_err), 32'd1);
        cyc(2'd0, 32'h0000_0020, 32'h0);
        chk("mis_unchanged", d_rd_data, 32'h5566_7788);
        cyc(2'd1, 32'h0000_0023, 32'h0000_0011);

        // Read-during-write returns old data
        cyc(2'd3, 32'h0000_0030, 32'h0);
        cyc(2'd3, 32'h0000_0030, 32'h1);
        chk("rdw_old", d_rd_data, 32'h0);
        cyc(2'd0, 32'h0000_0030, 32'h0);
        chk("rdw_new", d_rd_data, 32'h1);

        // High address bits alias in RAM space
        cyc(2'd3, 32'h1000_0050, 32'hCAFE_F00D);
        cyc(2'd0, 32'h0000_0050, 32'h0);
        chk("alias", d_rd_data, 32'hCAFE_F00D);

        // Coherent 64-bit read across a low-word wrap
        force dut.u_timer.mtime = 64'h0000_0005_FFFF_FFFF;
        #1 release dut.u_timer.mtime;
        m_mtime = 64'h0000_0005_FFFF_FFFF;
        cyc(2'd0, 32'h8000_0000, 32'h0);
        chk("mtime_lo", d_rd_data, 32'hFFFF_FFFF);
        cyc(2'd0, 32'h8000_0004, 32'h0);
        chk("mtime_hi_shadow", d_rd_data, 32'h5);
        cyc(2'd0, 32'h8000_0000, 32'h0);
        chk("mtime_lo2", d_rd_data, 32'h1);
        cyc(2'd0, 32'h8000_0004, 32'h0);
        chk("mtime_hi2", d_rd_data, 32'h6);

        // GPIO, TOHOST and illegal MMIO stores
        cyc(2'd3, 32'h8000_0010, 32'h1234_5678);
        chk("gpio_set", gpio_out, 32'h1234_5678);
        cyc(2'd1, 32'h8000_0010, 32'h0000_00FF);
        chk("gpio_sb_err", 32'(access_err), 32'd1);
        chk("gpio_kept", gpio_out, 32'h1234_5678);
        cyc(2'd3, 32'h8000_0000, 32'h0);
        chk("mtime_wr_err", 32'(access_err), 32'd1);
        cyc(2'd3, 32'h8000_0018, 32'h0);
        chk("unmapped_err", 32'(access_err), 32'd1);
        cyc(2'd0, 32'h8000_0018, 32'h0);
        chk("unmapped_rd", d_rd_data, 32'h0);
        cyc(2'd3, 32'h8000_0014, 32'h1);
        chk("halt_set", 32'(halt), 32'd1);
        chk("tohost_1", tohost_val, 32'h1);
        cyc(2'd3, 32'h8000_0014, 32'h7);
        chk("tohost_7", tohost_val, 32'h7);
        cyc(2'd0, 32'h8000_0014, 32'h0);
        chk("tohost_rd0", d_rd_data, 32'h0);
        cyc(2'd0, 32'h0000_0010, 32'h0);

        // Asynchronous reset mid-run
        d_we = 2'd0;
        #2 rst = 1'b0;
        #1;
        chk("arst_rd",     d_rd_data,        32'h0);
        chk("arst_gpio",   gpio_out,         32'h0);
        chk("arst_halt",   32'(halt),        32'h0);
        chk("arst_tohost", tohost_val,       32'h0);
        chk("arst_irq",    32'(timer_irq),   32'h0);
        model_reset();
        cyc(2'd0, 32'h0000_0010, 32'h0);
        cyc(2'd0, 32'h0000_0010, 32'h0);
        rst = 1'b1;
        cyc(2'd0, 32'h8000_0008, 32'h0);
        chk("cmp_after_rst", d_rd_data, 32'hFFFF_FFFF);
        cyc(2'd0, 32'h0000_0010, 32'h0);
        chk("ram_kept", d_rd_data, 32'h1234_AAEF);
        cyc(2'd0, 32'h8000_0000, 32'h0);
        cyc(2'd0, 32'h8000_0004, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
